// File: rtl/aes_state_array.sv
// AES/Rijndael state array: ROWS x COLS byte matrix with column write/XOR,
// registered column read, parallel load, and a stepwise in-place
// ShiftRows / InvShiftRows / clear engine behind a valid/ready command port.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | accepts loads, column writes and commands
// SHIFT    | one left-rotation step per cycle on rows r >= r_k
// INVSHIFT | one right-rotation step per cycle on rows r >= r_k
// CLEAR    | single step: zero the array (skipped when r_nop is set)
module aes_state_array #(
  parameter  int ROWS    = 4,
  parameter  int COLS    = 4,
  parameter  int BYTE_W  = 8,
  localparam int COL_W   = ROWS * BYTE_W,
  localparam int STATE_W = ROWS * COLS * BYTE_W,
  localparam int CIDX_W  = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic               wr_xor,
  input  logic [CIDX_W-1:0]  wr_col,
  input  logic [COL_W-1:0]   wr_data,
  input  logic               ld_en,
  input  logic [STATE_W-1:0] ld_data,
  input  logic               rd_en,
  input  logic [CIDX_W-1:0]  rd_col,
  output logic [COL_W-1:0]   rd_data,
  output logic               rd_valid,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd_op,
  output logic               cmd_ready,
  output logic               busy,
  output logic               done,
  output logic               wr_drop,
  output logic [STATE_W-1:0] state_out
);

  localparam int K_W = $clog2(ROWS);

  typedef enum logic [1:0] {IDLE, SHIFT, INVSHIFT, CLEAR} state_t;

  state_t            r_state, w_state_nxt;
  logic [K_W-1:0]    r_k, w_k_nxt;
  logic              r_nop, w_nop_nxt;
  logic              r_done, w_done_nxt;
  logic              r_wr_drop, w_drop_nxt;
  logic [BYTE_W-1:0] r_s     [ROWS][COLS];
  logic [BYTE_W-1:0] w_s_nxt [ROWS][COLS];
  logic [COL_W-1:0]  w_rd_col_data;
  logic              w_busy;
  logic              w_last;

  assign w_busy    = (r_state != IDLE);
  assign w_last    = (r_k == K_W'(ROWS - 1));
  assign cmd_ready = !w_busy;
  assign busy      = w_busy;
  assign done      = r_done;
  assign wr_drop   = r_wr_drop;

  // Next-state, array update and step sequencing.
  always_comb begin
    w_s_nxt     = r_s;
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_nop_nxt   = r_nop;
    w_done_nxt  = 1'b0;
    w_drop_nxt  = w_busy & (wr_en | ld_en);
    case (r_state)
      IDLE: begin
        if (ld_en) begin
          for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
              w_s_nxt[r][c] = ld_data[STATE_W-1-(c*ROWS+r)*BYTE_W -: BYTE_W];
        end else if (wr_en) begin
          // Out-of-range columns match no c and are silently dropped.
          for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
              if (wr_col == CIDX_W'(c))
                w_s_nxt[r][c] = wr_xor
                  ? (r_s[r][c] ^ wr_data[COL_W-1-r*BYTE_W -: BYTE_W])
                  : wr_data[COL_W-1-r*BYTE_W -: BYTE_W];
        end
        if (cmd_valid) begin
          w_k_nxt = K_W'(1);
          case (cmd_op)
            2'b00:   w_state_nxt = SHIFT;
            2'b01:   w_state_nxt = INVSHIFT;
            2'b10:   begin w_state_nxt = CLEAR; w_nop_nxt = 1'b0; end
            default: begin w_state_nxt = CLEAR; w_nop_nxt = 1'b1; end
          endcase
        end
      end
      SHIFT, INVSHIFT: begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            if (r >= int'(r_k))
              w_s_nxt[r][c] = (r_state == SHIFT) ? r_s[r][(c + 1) % COLS]
                                                 : r_s[r][(c + COLS - 1) % COLS];
        if (w_last) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_k_nxt = r_k + K_W'(1);
        end
      end
      CLEAR: begin
        if (!r_nop)
          for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
              w_s_nxt[r][c] = '0;
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Column select for the read port; out-of-range columns read as zero.
  always_comb begin
    w_rd_col_data = '0;
    for (int c = 0; c < COLS; c++)
      if (rd_col == CIDX_W'(c))
        for (int r = 0; r < ROWS; r++)
          w_rd_col_data[COL_W-1-r*BYTE_W -: BYTE_W] = r_s[r][c];
  end

  // Flatten the array into the packed column-major output.
  always_comb begin
    state_out = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        state_out[STATE_W-1-(c*ROWS+r)*BYTE_W -: BYTE_W] = r_s[r][c];
  end

  // State register, array storage and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_k       <= '0;
      r_nop     <= 1'b0;
      r_done    <= 1'b0;
      r_wr_drop <= 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          r_s[r][c] <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_k       <= w_k_nxt;
      r_nop     <= w_nop_nxt;
      r_done    <= w_done_nxt;
      r_wr_drop <= w_drop_nxt;
      r_s       <= w_s_nxt;
    end
  end

  // Registered read port; data holds until the next request.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= w_rd_col_data;
    end
  end

endmodule
